// File: rtl/tx_os_generator.sv
// Ordered-set generator: latches a TS1/TS2/EIOS/SKP/IDLE request from the LTSSM and
// streams it, lowest symbol first, on every lane of the PIPE TX bus.
module tx_os_generator #(
    parameter int         MAXPIPEWIDTH = 32,
    parameter int         PIPEWIDTH    = 8,
    parameter int         LANESNUMBER  = 16,
    parameter logic [7:0] NFTS         = 8'hFF
) (
    input  logic                                    Pclk,
    input  logic                                    Reset,
    input  logic [2:0]                              OSType,
    input  logic [1:0]                              LaneNumber,
    input  logic [7:0]                              LinkNumber,
    input  logic [2:0]                              Rate,
    input  logic                                    Loopback,
    input  logic                                    OSGeneratorStart,
    output logic                                    OSGeneratorBusy,
    output logic                                    OSGeneratorFinish,
    output logic [LANESNUMBER*MAXPIPEWIDTH-1:0]     TxData,
    output logic [LANESNUMBER*(MAXPIPEWIDTH/8)-1:0] TxDataK,
    output logic                                    TxDataValid
);
    localparam int SYMS    = PIPEWIDTH / 8;
    localparam int MAXSYMS = MAXPIPEWIDTH / 8;

    localparam logic [0:0] SIDLE = 1'b0;
    localparam logic [0:0] SSEND = 1'b1;

    localparam logic [2:0] KIND_TS1  = 3'd0;
    localparam logic [2:0] KIND_TS2  = 3'd1;
    localparam logic [2:0] KIND_EIOS = 3'd2;
    localparam logic [2:0] KIND_SKP  = 3'd3;
    localparam logic [2:0] KIND_IDLE = 3'd4;

    localparam logic [4:0] NB_LONG  = 5'(16 / SYMS);
    localparam logic [4:0] NB_SHORT = (SYMS >= 4) ? 5'd1 : 5'(4 / SYMS);

    logic [0:0] state_q, state_d;
    logic [4:0] beat_q, beat_d;
    logic [4:0] nbeats_q, nbeats_d;
    logic [2:0] kind_q, kind_d;
    logic       seq_q, seq_d;
    logic [7:0] link_q, link_d;
    logic [7:0] rate_id_q, rate_id_d;
    logic       loopback_q, loopback_d;
    logic [2:0] req_kind;
    logic [8:0] sym;

    // Rate identifier: bit 1 always set, bits 2..Rate mark the higher gens.
    function automatic logic [7:0] rate_ident(input logic [2:0] rate);
        logic [2:0] r;
        logic [7:0] rid;
        r   = (rate == 3'd0 || rate > 3'd5) ? 3'd1 : rate;
        rid = 8'b0000_0010;
        for (int k = 2; k <= 5; k++) begin
            if (k <= int'(r)) rid[k] = 1'b1;
        end
        return rid;
    endfunction

    // Returns {K, byte} for symbol s of the latched set.
    function automatic logic [8:0] os_symbol(input logic [2:0] kind, input int s,
                                             input logic [7:0] lane_id, input logic seq,
                                             input logic [7:0] link, input logic [7:0] rid,
                                             input logic lb);
        logic [8:0] res;
        res = 9'h000;
        case (kind)
            KIND_TS1, KIND_TS2: begin
                case (s)
                    0:       res = {1'b1, 8'hBC};
                    1:       res = (link == 8'h00) ? {1'b1, 8'hF7} : {1'b0, link};
                    2:       res = seq ? {1'b0, lane_id} : {1'b1, 8'hF7};
                    3:       res = {1'b0, NFTS};
                    4:       res = {1'b0, rid};
                    5:       res = {1'b0, 5'b0, lb, 2'b0};
                    default: res = (kind == KIND_TS1) ? {1'b0, 8'h4A} : {1'b0, 8'h45};
                endcase
            end
            KIND_EIOS: res = (s == 0) ? {1'b1, 8'hBC} : {1'b1, 8'h7C};
            KIND_SKP:  res = (s == 0) ? {1'b1, 8'hBC} : {1'b1, 8'h1C};
            default:   res = 9'h000;
        endcase
        return res;
    endfunction

    always_comb begin
        req_kind = (OSType <= 3'd3) ? OSType : KIND_IDLE;
        state_d    = state_q;
        beat_d     = beat_q;
        nbeats_d   = nbeats_q;
        kind_d     = kind_q;
        seq_d      = seq_q;
        link_d     = link_q;
        rate_id_d  = rate_id_q;
        loopback_d = loopback_q;
        case (state_q)
            SIDLE: begin
                if (OSGeneratorStart) begin
                    state_d    = SSEND;
                    beat_d     = 5'd0;
                    kind_d     = req_kind;
                    seq_d      = (LaneNumber == 2'b01);
                    link_d     = LinkNumber;
                    rate_id_d  = rate_ident(Rate);
                    loopback_d = Loopback;
                    nbeats_d   = (req_kind == KIND_EIOS || req_kind == KIND_SKP) ? NB_SHORT : NB_LONG;
                end
            end
            default: begin
                if (beat_q == nbeats_q - 5'd1) begin
                    state_d = SIDLE;
                    beat_d  = 5'd0;
                end else begin
                    beat_d = beat_q + 5'd1;
                end
            end
        endcase
    end

    always_ff @(posedge Pclk) begin
        if (!Reset) begin
            state_q <= SIDLE;
            beat_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Request fields are only meaningful while SSEND, so they need no reset.
    always_ff @(posedge Pclk) begin
        nbeats_q   <= nbeats_d;
        kind_q     <= kind_d;
        seq_q      <= seq_d;
        link_q     <= link_d;
        rate_id_q  <= rate_id_d;
        loopback_q <= loopback_d;
    end

    always_comb begin
        TxData  = '0;
        TxDataK = '0;
        sym     = 9'h000;
        if (state_q == SSEND) begin
            for (int lane = 0; lane < LANESNUMBER; lane++) begin
                for (int j = 0; j < SYMS; j++) begin
                    sym = os_symbol(kind_q, int'(beat_q) * SYMS + j, 8'(lane), seq_q,
                                    link_q, rate_id_q, loopback_q);
                    TxData[lane*MAXPIPEWIDTH + 8*j +: 8] = sym[7:0];
                    TxDataK[lane*MAXSYMS + j]            = sym[8];
                end
            end
        end
    end

    assign OSGeneratorBusy   = (state_q == SSEND);
    assign TxDataValid       = (state_q == SSEND);
    assign OSGeneratorFinish = (state_q == SSEND) && (beat_q == nbeats_q - 5'd1);

endmodule

// File: tb/tb_tx_os_generator.sv
// Bench for tx_os_generator: three widths (8/16/32) driven in parallel, each checked every
// cycle against a set-level model that rebuilds the symbol list from the request fields.
module tb_tx_os_generator;
    localparam int LN = 16;
    localparam int MW = 32;
    localparam int DW = LN * MW;
    localparam int KW = LN * (MW / 8);

    logic          Pclk = 1'b0;
    logic          Reset = 1'b0;
    logic [2:0]    OSType = 3'd0;
    logic [1:0]    LaneNumber = 2'd0;
    logic [7:0]    LinkNumber = 8'd0;
    logic [2:0]    Rate = 3'd1;
    logic          Loopback = 1'b0;
    logic          Start = 1'b0;

    logic [DW-1:0] d8, d16, d32;
    logic [KW-1:0] k8, k16, k32;
    logic          b8, b16, b32, f8, f16, f32, v8, v16, v32;

    tx_os_generator #(.MAXPIPEWIDTH(MW), .PIPEWIDTH(8), .LANESNUMBER(LN), .NFTS(8'hFF)) u8 (
        .Pclk(Pclk), .Reset(Reset), .OSType(OSType), .LaneNumber(LaneNumber),
        .LinkNumber(LinkNumber), .Rate(Rate), .Loopback(Loopback), .OSGeneratorStart(Start),
        .OSGeneratorBusy(b8), .OSGeneratorFinish(f8), .TxData(d8), .TxDataK(k8), .TxDataValid(v8));
    tx_os_generator #(.MAXPIPEWIDTH(MW), .PIPEWIDTH(16), .LANESNUMBER(LN), .NFTS(8'hFF)) u16 (
        .Pclk(Pclk), .Reset(Reset), .OSType(OSType), .LaneNumber(LaneNumber),
        .LinkNumber(LinkNumber), .Rate(Rate), .Loopback(Loopback), .OSGeneratorStart(Start),
        .OSGeneratorBusy(b16), .OSGeneratorFinish(f16), .TxData(d16), .TxDataK(k16), .TxDataValid(v16));
    tx_os_generator #(.MAXPIPEWIDTH(MW), .PIPEWIDTH(32), .LANESNUMBER(LN), .NFTS(8'hFF)) u32 (
        .Pclk(Pclk), .Reset(Reset), .OSType(OSType), .LaneNumber(LaneNumber),
        .LinkNumber(LinkNumber), .Rate(Rate), .Loopback(Loopback), .OSGeneratorStart(Start),
        .OSGeneratorBusy(b32), .OSGeneratorFinish(f32), .TxData(d32), .TxDataK(k32), .TxDataValid(v32));

    always #5 Pclk = ~Pclk;

    int errors = 0;
    int checks = 0;

    int         W[3] = '{8, 16, 32};
    logic [7:0] m_sym[3][16];
    logic       m_k[3][16];
    logic       m_seq[3];
    int         m_rem[3] = '{0, 0, 0};
    int         m_beat[3] = '{0, 0, 0};
    int         m_nb[3] = '{1, 1, 1};

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Symbol list of the requested set, straight from the ordered-set definitions.
    task automatic load_set(input int i);
        int         len;
        int         r;
        logic [7:0] fill;
        for (int s = 0; s < 16; s++) begin
            m_sym[i][s] = 8'h00;
            m_k[i][s]   = 1'b0;
        end
        m_seq[i] = 1'b0;
        case (OSType)
            3'd0, 3'd1: begin
                len  = 16;
                fill = (OSType == 3'd0) ? 8'h4A : 8'h45;
                r    = (Rate == 3'd0 || Rate > 3'd5) ? 1 : int'(Rate);
                m_sym[i][0] = 8'hBC; m_k[i][0] = 1'b1;
                if (LinkNumber == 8'h00) begin
                    m_sym[i][1] = 8'hF7; m_k[i][1] = 1'b1;
                end else begin
                    m_sym[i][1] = LinkNumber;
                end
                m_sym[i][2] = 8'hF7; m_k[i][2] = 1'b1;
                m_seq[i]    = (LaneNumber == 2'b01);
                m_sym[i][3] = 8'hFF;
                m_sym[i][4] = 8'(((1 << (r + 1)) - 1) & 'hFE);
                m_sym[i][5] = Loopback ? 8'h04 : 8'h00;
                for (int s = 6; s < 16; s++) m_sym[i][s] = fill;
            end
            3'd2, 3'd3: begin
                len = 4;
                for (int s = 0; s < 4; s++) begin
                    m_sym[i][s] = (s == 0) ? 8'hBC : ((OSType == 3'd2) ? 8'h7C : 8'h1C);
                    m_k[i][s]   = 1'b1;
                end
            end
            default: len = 16;
        endcase
        m_nb[i] = (len * 8 / W[i] < 1) ? 1 : len * 8 / W[i];
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (!Reset) begin
                m_rem[i] = 0;
            end else if (m_rem[i] > 0) begin
                m_rem[i]--;
                m_beat[i]++;
            end else if (Start) begin
                load_set(i);
                m_beat[i] = 0;
                m_rem[i]  = m_nb[i];
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            logic [DW-1:0] ed, ad;
            logic [KW-1:0] ek, ak;
            logic          eb, ef, ab, af, av;
            int            syms, s;
            logic [7:0]    b;
            logic          kk;
            syms = W[i] / 8;
            ed = '0; ek = '0;
            eb = (m_rem[i] > 0);
            ef = (m_rem[i] == 1);
            if (eb) begin
                for (int lane = 0; lane < LN; lane++) begin
                    for (int j = 0; j < syms; j++) begin
                        s  = m_beat[i] * syms + j;
                        b  = m_sym[i][s];
                        kk = m_k[i][s];
                        if (s == 2 && m_seq[i]) begin
                            b  = 8'(lane);
                            kk = 1'b0;
                        end
                        ed[lane*MW + 8*j +: 8] = b;
                        ek[lane*(MW/8) + j]    = kk;
                    end
                end
            end
            case (i)
                0:       begin ad = d8;  ak = k8;  ab = b8;  af = f8;  av = v8;  end
                1:       begin ad = d16; ak = k16; ab = b16; af = f16; av = v16; end
                default: begin ad = d32; ak = k32; ab = b32; af = f32; av = v32; end
            endcase
            chk($sformatf("w%0d_busy", W[i]), DW'(ab), DW'(eb));
            chk($sformatf("w%0d_valid", W[i]), DW'(av), DW'(eb));
            chk($sformatf("w%0d_finish", W[i]), DW'(af), DW'(ef));
            chk($sformatf("w%0d_data", W[i]), ad, ed);
            chk($sformatf("w%0d_datak", W[i]), DW'(ak), DW'(ek));
        end
    endtask

    task automatic tick();
        @(posedge Pclk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((m_rem[0] > 0 || m_rem[1] > 0 || m_rem[2] > 0) && c < 100) begin
            tick();
            c++;
        end
        tick();
    endtask

    initial begin
        int n;
        Reset = 1'b0;
        repeat (3) tick();
        chk("reset_busy", DW'(b8 | b16 | b32), '0);
        chk("reset_data", d8 | d16 | d32, '0);
        Reset = 1'b1;
        tick();

        // TS1, link 1, sequential lanes, gen1
        OSType = 3'd0; LinkNumber = 8'h01; LaneNumber = 2'b01; Rate = 3'd1; Loopback = 1'b0;
        Start = 1'b1; tick(); Start = 1'b0;
        n = 0;
        for (int b = 0; b < 16; b++) begin
            if (b == 0) chk("ts1_lane3_s0", DW'({k8[3*4], d8[3*32 +: 8]}), DW'(9'h1BC));
            if (b == 2) chk("ts1_lane3_s2", DW'(d8[3*32 +: 8]), DW'(8'h03));
            if (b == 4) chk("ts1_lane3_s4", DW'(d8[3*32 +: 8]), DW'(8'h02));
            if (b == 15) chk("ts1_finish_last", DW'(f8), DW'(1'b1));
            n += int'(b8);
            tick();
        end
        chk("ts1_busy_cycles", DW'(n), DW'(16));
        chk("ts1_idle_after", DW'(b8), '0);
        wait_idle();

        // TS2, PAD link/lane, gen3, loopback, width 32
        OSType = 3'd1; LinkNumber = 8'h00; LaneNumber = 2'b00; Rate = 3'd3; Loopback = 1'b1;
        Start = 1'b1; tick(); Start = 1'b0;
        chk("ts2_beat0", DW'(d32[31:0]), DW'(32'hFFF7F7BC));
        chk("ts2_beat0_k", DW'(k32[3:0]), DW'(4'b0111));
        tick();
        chk("ts2_beat1", DW'(d32[31:0]), DW'(32'h4545040E));
        chk("ts2_beat1_k", DW'(k32[3:0]), DW'(4'b0000));
        wait_idle();

        // EIOS: single beat at width 32
        OSType = 3'd2;
        Start = 1'b1; tick(); Start = 1'b0;
        chk("eios_beat", DW'(d32[31:0]), DW'(32'h7C7C7CBC));
        chk("eios_k", DW'(k32[3:0]), DW'(4'hF));
        chk("eios_busy_fin", DW'({b32, f32}), DW'(2'b11));
        tick();
        chk("eios_done", DW'(b32), '0);
        wait_idle();

        // Start held high: back-to-back TS1 with a single idle cycle between sets
        OSType = 3'd0; LinkNumber = 8'h05; LaneNumber = 2'b01; Rate = 3'd5; Loopback = 1'b0;
        Start = 1'b1;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            n += int'(f8);
        end
        Start = 1'b0;
        chk("held_start_finishes", DW'(n), DW'(3));
        wait_idle();

        // Start pulse during Busy with a different type is ignored
        OSType = 3'd0; Start = 1'b1; tick(); Start = 1'b0;
        repeat (3) tick();
        OSType = 3'd2; Start = 1'b1; tick(); Start = 1'b0; OSType = 3'd0;
        wait_idle();

        // Reset in the middle of a TS1
        OSType = 3'd0; LinkNumber = 8'h22; LaneNumber = 2'b10; Rate = 3'd2;
        Start = 1'b1; tick(); Start = 1'b0;
        repeat (5) tick();
        Reset = 1'b0; tick();
        chk("midreset_outputs", d8 | DW'(k8) | DW'({b8, f8, v8}), '0);
        Reset = 1'b1; tick();
        Start = 1'b1; tick(); Start = 1'b0;
        chk("restart_s0", DW'({k8[0], d8[7:0]}), DW'(9'h1BC));
        wait_idle();

        // Reserved OSType treated as IDLE
        OSType = 3'b111;
        Start = 1'b1; tick(); Start = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            n += int'(b16);
            tick();
        end
        chk("idle_w16_beats", DW'(n), DW'(8));
        wait_idle();

        // Random request traffic, random Start timing, occasional reset
        for (int c = 0; c < 400; c++) begin
            OSType     = 3'($urandom_range(0, 7));
            LinkNumber = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            LaneNumber = 2'($urandom_range(0, 3));
            Rate       = 3'($urandom_range(0, 7));
            Loopback   = 1'($urandom_range(0, 1));
            Start      = 1'($urandom_range(0, 2) != 0);
            Reset      = ($urandom_range(0, 39) != 0);
            tick();
        end
        Start = 1'b0; Reset = 1'b1;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
